// File: rtl/mem_stage_if.sv
// Data-bus request/ack channel between the memory stage and the data memory.
interface mem_stage_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    ack;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on the data bus with lane steering,
// stalls the pipe while an access is outstanding, and registers the writeback triple.
module mem_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic [3:0]            mem_op_i,
  input  logic [4:0]            reg_waddr_i,
  input  logic                  reg_we_i,
  input  logic [DATA_WIDTH-1:0] reg_wdata_i,
  mem_stage_if.master           dbus,
  output logic [4:0]            reg_waddr_o,
  output logic                  reg_we_o,
  output logic [DATA_WIDTH-1:0] reg_wdata_o,
  output logic                  stallreq_o,
  output logic                  excp_misalign_o,
  output logic                  excp_buserr_o
);
  localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                         OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  typedef enum logic {S_IDLE, S_BUS} state_t;
  state_t r_state, w_state_nxt;

  logic                  r_req, r_dwe, r_mis, r_berr, r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_be, r_op;
  logic [31:0]           r_wd, r_wdata, r_cnt;
  logic [1:0]            r_alo;
  logic [4:0]            r_rd, r_waddr;

  logic        w_is_ld, w_is_st, w_is_mem, w_misal, w_start, w_done, w_tmo;
  logic [3:0]  w_be;
  logic [31:0] w_wd, w_ld;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unused;

  // Store direction comes from the op decode; the separate store flag is redundant.
  assign w_unused = mem_we_i;

  always_comb begin
    w_is_ld  = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LHU);
    w_is_st  = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
    w_is_mem = w_is_ld || w_is_st;
    w_misal  = (((mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH)) && mem_addr_i[0])
            || (((mem_op_i == OP_LW) || (mem_op_i == OP_SW)) && (mem_addr_i[1:0] != 2'b00));
    w_be = 4'b1111;
    w_wd = '0;
    case (mem_op_i)
      OP_SB:   begin w_wd = {4{mem_data_i[7:0]}};  w_be = 4'b0001 << mem_addr_i[1:0]; end
      OP_SH:   begin w_wd = {2{mem_data_i[15:0]}}; w_be = mem_addr_i[1] ? 4'b1100 : 4'b0011; end
      OP_SW:   w_wd = mem_data_i;
      default: ;
    endcase
  end

  always_comb begin
    case (r_alo)
      2'd0:    w_byte = dbus.rdata[7:0];
      2'd1:    w_byte = dbus.rdata[15:8];
      2'd2:    w_byte = dbus.rdata[23:16];
      default: w_byte = dbus.rdata[31:24];
    endcase
    w_half = r_alo[1] ? dbus.rdata[31:16] : dbus.rdata[15:0];
    case (r_op)
      OP_LB:   w_ld = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_ld = {24'd0, w_byte};
      OP_LH:   w_ld = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_ld = {16'd0, w_half};
      default: w_ld = dbus.rdata;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: if (w_is_mem && !w_misal) begin w_start = 1'b1; w_state_nxt = S_BUS; end
      S_BUS: begin
        if (dbus.ack) begin
          w_done = 1'b1;
          w_state_nxt = S_IDLE;
        end else if ((TIMEOUT != 0) && (r_cnt == 32'(TIMEOUT - 1))) begin
          w_tmo = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_req <= 1'b0; r_dwe <= 1'b0; r_addr <= '0; r_be <= '0; r_wd <= '0;
      r_op <= '0; r_alo <= '0; r_rd <= '0; r_cnt <= '0;
      r_waddr <= '0; r_we <= 1'b0; r_wdata <= '0; r_mis <= 1'b0; r_berr <= 1'b0;
    end else begin
      r_mis  <= 1'b0;
      r_berr <= 1'b0;
      if (r_state == S_IDLE) begin
        if (!w_is_mem) begin
          r_waddr <= reg_waddr_i;
          r_we    <= reg_we_i;
          r_wdata <= reg_wdata_i;
        end else begin
          r_we <= 1'b0;
          if (w_misal) r_mis <= 1'b1;
          if (w_start) begin
            r_req  <= 1'b1;
            r_dwe  <= w_is_st;
            r_addr <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
            r_be   <= w_be;
            r_wd   <= w_wd;
            r_op   <= mem_op_i;
            r_alo  <= mem_addr_i[1:0];
            r_rd   <= reg_waddr_i;
            r_cnt  <= '0;
          end
        end
      end else begin
        r_we <= 1'b0;
        if (w_done) begin
          r_req <= 1'b0;
          if (!r_dwe) begin
            r_we    <= 1'b1;
            r_waddr <= r_rd;
            r_wdata <= w_ld;
          end
        end else if (w_tmo) begin
          r_req  <= 1'b0;
          r_berr <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 32'd1;
        end
      end
    end
  end

  assign dbus.req        = r_req;
  assign dbus.we         = r_dwe;
  assign dbus.addr       = r_addr;
  assign dbus.be         = r_be;
  assign dbus.wdata      = r_wd;
  assign reg_waddr_o     = r_waddr;
  assign reg_we_o        = r_we;
  assign reg_wdata_o     = r_wdata;
  assign excp_misalign_o = r_mis;
  assign excp_buserr_o   = r_berr;
  // A pending access stalls until the ack cycle itself, so the frozen op advances on the ack edge.
  assign stallreq_o      = rst_i & ((r_state == S_IDLE) ? w_start : ~dbus.ack);
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: writebacks are checked against a scoreboard queue.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_we_i;
  logic [31:0] mem_addr_i, mem_data_i, reg_wdata_i;
  logic [3:0]  mem_op_i;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [31:0] reg_wdata_o;
  logic        stallreq_o, excp_misalign_o, excp_buserr_o;

  mem_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_op_i(mem_op_i), .reg_waddr_i(reg_waddr_i),
    .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i), .dbus(bus.master),
    .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
    .stallreq_o(stallreq_o), .excp_misalign_o(excp_misalign_o), .excp_buserr_o(excp_buserr_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] d; } wb_t;
  wb_t sb_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Writeback monitor: every retired writeback must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && reg_we_o === 1'b1) begin
      if (sb_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
      else begin
        wb_t e;
        e = sb_q.pop_front();
        chk("wb_rd", {27'd0, reg_waddr_o}, {27'd0, e.rd});
        chk("wb_data", reg_wdata_o, e.d);
      end
    end
  end

  task automatic set_idle();
    mem_op_i = 4'd0; mem_we_i = 1'b0; mem_addr_i = '0; mem_data_i = '0;
    reg_waddr_i = '0; reg_we_i = 1'b0; reg_wdata_i = '0;
  endtask

  task automatic present(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd);
    mem_op_i = op; mem_addr_i = a; mem_data_i = d; reg_waddr_i = rd;
    mem_we_i = (op >= 4'd6) && (op <= 4'd8);
    reg_we_i = ~mem_we_i; reg_wdata_i = 32'hDEAD_BEEF;
  endtask

  task automatic mem_acc(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd, input int waits,
                         input logic [31:0] rdata, input logic [3:0] ebe,
                         input logic [31:0] ewd, input logic [31:0] eld);
    int stalls;
    logic st;
    st = (op >= 4'd6);
    present(op, a, d, rd);
    #1;
    chk({tag, "_stall_issue"}, {31'd0, stallreq_o}, 32'd1);
    stalls = int'(stallreq_o);
    @(posedge clk); #1;
    chk({tag, "_req"}, {31'd0, bus.req}, 32'd1);
    chk({tag, "_we"}, {31'd0, bus.we}, {31'd0, st});
    chk({tag, "_addr"}, bus.addr, {a[31:2], 2'b00});
    chk({tag, "_be"}, {28'd0, bus.be}, {28'd0, ebe});
    if (st) chk({tag, "_wdata"}, bus.wdata, ewd);
    for (int i = 0; i < waits; i++) begin
      if (stallreq_o) stalls++;
      @(posedge clk); #1;
      chk({tag, "_req_hold"}, {31'd0, bus.req}, 32'd1);
    end
    bus.ack = 1'b1; bus.rdata = rdata;
    if (!st) sb_q.push_back('{rd: rd, d: eld});
    #1;
    chk({tag, "_stall_ack"}, {31'd0, stallreq_o}, 32'd0);
    chk({tag, "_stall_cycles"}, stalls, waits + 1);
    @(posedge clk); #1;
    bus.ack = 1'b0; bus.rdata = '0;
    set_idle();
    chk({tag, "_req_drop"}, {31'd0, bus.req}, 32'd0);
    if (st) chk({tag, "_store_no_wb"}, {31'd0, reg_we_o}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.ack = 1'b1; bus.rdata = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    present(4'd3, 32'h0000_0010, 32'h5555_5555, 5'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, bus.req}, 32'd0);
    chk("rst_dwe", {31'd0, bus.we}, 32'd0);
    chk("rst_addr", bus.addr, 32'd0);
    chk("rst_be", {28'd0, bus.be}, 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    chk("rst_reg", {reg_waddr_o, reg_we_o, 26'd0}, 32'd0);
    chk("rst_rwdata", reg_wdata_o, 32'd0);
    chk("rst_excp", {30'd0, excp_misalign_o, excp_buserr_o}, 32'd0);
    chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
    bus.ack = 1'b0; bus.rdata = '0;
    set_idle();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU result passes straight through with one cycle of latency
    mem_op_i = 4'd0; reg_waddr_i = 5'd5; reg_we_i = 1'b1; reg_wdata_i = 32'h0000_1234;
    sb_q.push_back('{rd: 5'd5, d: 32'h0000_1234});
    #1;
    chk("addi_stall", {31'd0, stallreq_o}, 32'd0);
    @(posedge clk); #1;
    chk("addi_wdata", reg_wdata_o, 32'h0000_1234);
    chk("addi_we", {31'd0, reg_we_o}, 32'd1);
    chk("addi_noreq", {31'd0, bus.req}, 32'd0);
    set_idle();
    @(posedge clk); #1;

    mem_acc("lb",  4'd1, 32'h0000_0103, 32'd0, 5'd7, 2, 32'h80FF_0011, 4'b1111, 32'd0, 32'hFFFF_FF80);
    mem_acc("lhu", 4'd5, 32'h0000_0102, 32'd0, 5'd8, 0, 32'hBEEF_0000, 4'b1111, 32'd0, 32'h0000_BEEF);
    mem_acc("lh",  4'd2, 32'h0000_0106, 32'd0, 5'd9, 1, 32'h9ABC_0000, 4'b1111, 32'd0, 32'hFFFF_9ABC);
    mem_acc("lbu", 4'd4, 32'h0000_0101, 32'd0, 5'd10, 0, 32'h0000_F200, 4'b1111, 32'd0, 32'h0000_00F2);
    mem_acc("lw",  4'd3, 32'h0000_0108, 32'd0, 5'd0, 1, 32'hCAFE_F00D, 4'b1111, 32'd0, 32'hCAFE_F00D);
    mem_acc("sh",  4'd7, 32'h0000_0202, 32'h0000_ABCD, 5'd0, 1, 32'd0, 4'b1100, 32'hABCD_ABCD, 32'd0);
    mem_acc("sb",  4'd6, 32'h0000_0402, 32'h1234_5678, 5'd0, 0, 32'd0, 4'b0100, 32'h7878_7878, 32'd0);
    mem_acc("sw",  4'd8, 32'h0000_0404, 32'h1122_3344, 5'd0, 0, 32'd0, 4'b1111, 32'h1122_3344, 32'd0);

    // Misaligned word load: no access, one-cycle exception pulse
    present(4'd3, 32'h0000_0101, 32'd0, 5'd4);
    #1;
    chk("mis_stall", {31'd0, stallreq_o}, 32'd0);
    @(posedge clk); #1;
    chk("mis_pulse", {31'd0, excp_misalign_o}, 32'd1);
    chk("mis_noreq", {31'd0, bus.req}, 32'd0);
    set_idle();
    @(posedge clk); #1;
    chk("mis_pulse_end", {31'd0, excp_misalign_o}, 32'd0);

    // Ack never comes: bus error after TIMEOUT wait cycles
    present(4'd3, 32'h0000_0104, 32'd0, 5'd6);
    @(posedge clk); #1;
    chk("tmo_req", {31'd0, bus.req}, 32'd1);
    n = 0;
    while (excp_buserr_o !== 1'b1 && n < 10) begin
      chk("tmo_stall", {31'd0, stallreq_o}, 32'd1);
      @(posedge clk); #1;
      n++;
    end
    set_idle();
    chk("tmo_waits", n, 4);
    chk("tmo_pulse", {31'd0, excp_buserr_o}, 32'd1);
    chk("tmo_req_drop", {31'd0, bus.req}, 32'd0);
    #1;
    chk("tmo_stall_rel", {31'd0, stallreq_o}, 32'd0);
    @(posedge clk); #1;
    chk("tmo_pulse_end", {31'd0, excp_buserr_o}, 32'd0);

    // Reset in the middle of an access abandons it
    present(4'd3, 32'h0000_0300, 32'd0, 5'd11);
    @(posedge clk); #1;
    chk("rbus_req", {31'd0, bus.req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rbus_stall", {31'd0, stallreq_o}, 32'd0);
    @(posedge clk); #1;
    chk("rbus_req_drop", {31'd0, bus.req}, 32'd0);
    chk("rbus_no_wb", {31'd0, reg_we_o}, 32'd0);
    set_idle();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rbus_idle_req", {31'd0, bus.req}, 32'd0);
    chk("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
